// File: rtl/zvc_pkg.sv
// Shared constants and types for the zero-value compressor.
package zvc_pkg;

  // Line geometry is fixed. 128 kept words need the full 8-bit count.
  localparam int LINE_SIZE = 128;
  localparam int CNT_WIDTH = 8;

  // Default word and metadata geometry.
  localparam int DEF_WORD_WIDTH    = 8;
  localparam int DEF_DIST_WIDTH    = 7;
  localparam int DEF_MAX_LIFM_RSIZ = 4;
  localparam int MT_WIDTH          = DEF_DIST_WIDTH * DEF_MAX_LIFM_RSIZ;

  // One exclusive prefix count per word position.
  typedef logic [LINE_SIZE-1:0][CNT_WIDTH-1:0] pfx_arr_t;

endpackage

// File: rtl/zvc_prefix_count.sv
// Exclusive prefix count of a 128-bit keep mask, plus the total count.
// pfx[i] is the number of set mask bits strictly below i, which is the
// destination slot of word i when it is kept.
module zvc_prefix_count import zvc_pkg::*; (
  input  logic [LINE_SIZE-1:0] mask,
  output pfx_arr_t             pfx,
  output logic [CNT_WIDTH-1:0] total
);

  // Running count: each position records the count before adding itself.
  always_comb begin
    logic [CNT_WIDTH-1:0] acc;
    acc = '0;
    pfx = '0;
    for (int i = 0; i < LINE_SIZE; i++) begin
      pfx[i] = acc;
      acc    = acc + CNT_WIDTH'(mask[i]);
    end
    total = acc;
  end

endmodule

// File: rtl/zvc_compressor_128.sv
// Zero-value compressor for one 128-word LIFM line and its MT entries.
// Nonzero words (with their MT entry) are packed toward slot 0 in original
// order; unused slots read zero. Outputs are registered.
// Optional build macro ZVC_PIPE2_EN: adds a register stage after the prefix
// count (2-cycle latency, still one line per cycle).
module zvc_compressor_128 import zvc_pkg::*; #(
  parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int DIST_WIDTH    = DEF_DIST_WIDTH,
  parameter int MAX_LIFM_RSIZ = DEF_MAX_LIFM_RSIZ
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [LINE_SIZE*WORD_WIDTH-1:0]             lifm_line,
  input  logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_line,
  output logic [LINE_SIZE*WORD_WIDTH-1:0]             lifm_comp,
  output logic [LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ-1:0] mt_comp,
  output logic [CNT_WIDTH-1:0]                        comp_cnt
);

  localparam int MTW = DIST_WIDTH * MAX_LIFM_RSIZ;

  typedef logic [LINE_SIZE-1:0][WORD_WIDTH-1:0] word_arr_t;
  typedef logic [LINE_SIZE-1:0][MTW-1:0]        mt_arr_t;

  word_arr_t             in_w;
  mt_arr_t               in_m;
  logic [LINE_SIZE-1:0]  keep;
  pfx_arr_t              pfx;
  logic [CNT_WIDTH-1:0]  total;

  // Packed-array views share the flat port bit layout (word i at i*W).
  assign in_w = lifm_line;
  assign in_m = mt_line;

  // Keep decision looks only at the LIFM word; MT never affects it.
  for (genvar i = 0; i < LINE_SIZE; i++) begin : g_keep
    assign keep[i] = |in_w[i];
  end

  zvc_prefix_count u_pfx (
    .mask  (keep),
    .pfx   (pfx),
    .total (total)
  );

  // Select-stage operands: either the live inputs or a registered copy.
  word_arr_t             s_w;
  mt_arr_t               s_m;
  logic [LINE_SIZE-1:0]  s_keep;
  pfx_arr_t              s_pfx;
  logic [CNT_WIDTH-1:0]  s_cnt;

`ifdef ZVC_PIPE2_EN
  // Split point: hold the counts alongside the data they index.
  always_ff @(posedge clk) begin
    if (reset) begin
      s_w    <= '0;
      s_m    <= '0;
      s_keep <= '0;
      s_pfx  <= '0;
      s_cnt  <= '0;
    end else begin
      s_w    <= in_w;
      s_m    <= in_m;
      s_keep <= keep;
      s_pfx  <= pfx;
      s_cnt  <= total;
    end
  end
`else
  assign s_w    = in_w;
  assign s_m    = in_m;
  assign s_keep = keep;
  assign s_pfx  = pfx;
  assign s_cnt  = total;
`endif

  word_arr_t sel_w;
  mt_arr_t   sel_m;

  // Per-slot one-hot OR: at most one kept word has prefix count j, and only
  // words at index >= j can land in slot j. No match leaves the slot zero.
  for (genvar j = 0; j < LINE_SIZE; j++) begin : g_slot
    logic [WORD_WIDTH-1:0] w;
    logic [MTW-1:0]        m;

    // Gather the kept word whose destination is this slot.
    always_comb begin
      w = '0;
      m = '0;
      for (int i = j; i < LINE_SIZE; i++) begin
        if (s_keep[i] && (s_pfx[i] == CNT_WIDTH'(j))) begin
          w = w | s_w[i];
          m = m | s_m[i];
        end
      end
    end

    assign sel_w[j] = w;
    assign sel_m[j] = m;
  end

  // Output register; reset wins over the line sampled on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      lifm_comp <= '0;
      mt_comp   <= '0;
      comp_cnt  <= '0;
    end else begin
      lifm_comp <= sel_w;
      mt_comp   <= sel_m;
      comp_cnt  <= s_cnt;
    end
  end

endmodule

// File: tb/tb_zvc_compressor_128.sv
// Self-checking bench for zvc_compressor_128: scoreboard of expected
// compressed lines built by a behavioural scatter model.
module tb_zvc_compressor_128;

  localparam int NW = 128;
  localparam int WW = 8;
  localparam int MT = 28;
  localparam int LW = NW * WW;
  localparam int MW = NW * MT;
`ifdef ZVC_PIPE2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct packed {
    logic [LW-1:0] l;
    logic [MW-1:0] m;
    logic [7:0]    c;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [LW-1:0] lifm_line, lifm_comp;
  logic [MW-1:0] mt_line, mt_comp;
  logic [7:0]    comp_cnt;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Scenario lines shared by several tests.
  logic [LW-1:0] sp_l, b2_l;
  logic [MW-1:0] sp_m, b2_m;

  always #5 clk = ~clk;

  zvc_compressor_128 dut (
    .clk       (clk),
    .reset     (reset),
    .lifm_line (lifm_line),
    .mt_line   (mt_line),
    .lifm_comp (lifm_comp),
    .mt_comp   (mt_comp),
    .comp_cnt  (comp_cnt)
  );

  // Reference: walk the input and append each nonzero word to the output.
  function automatic exp_t model(input logic [LW-1:0] l, input logic [MW-1:0] m);
    exp_t e;
    int   k;
    e = '0;
    k = 0;
    for (int i = 0; i < NW; i++) begin
      if (l[i*WW +: WW] != '0) begin
        e.l[k*WW +: WW] = l[i*WW +: WW];
        e.m[k*MT +: MT] = m[i*MT +: MT];
        k++;
      end
    end
    e.c = 8'(k);
    return e;
  endfunction

  function automatic int ldiff(input logic [LW-1:0] a, input logic [LW-1:0] b);
    for (int i = 0; i < NW; i++) if (a[i*WW +: WW] !== b[i*WW +: WW]) return i;
    return -1;
  endfunction

  function automatic int mdiff(input logic [MW-1:0] a, input logic [MW-1:0] b);
    for (int i = 0; i < NW; i++) if (a[i*MT +: MT] !== b[i*MT +: MT]) return i;
    return -1;
  endfunction

  // Drive one line for one edge; push its expectation, pop the one due now.
  task automatic drive(input logic [LW-1:0] l, input logic [MW-1:0] m,
                       input logic r, output exp_t e);
    exp_t x;
    lifm_line = l;
    mt_line   = m;
    reset     = r;
    x = r ? exp_t'('0) : model(l, m);
    @(posedge clk);
    if (r) begin
      q.delete();
      repeat (LAT-1) q.push_back(exp_t'('0));
    end
    q.push_back(x);
    #1;
    e = q.pop_front();
  endtask

  task automatic test_reset();
    logic [LW-1:0] l;
    logic [MW-1:0] m;
    exp_t e;
    for (int k = 0; k < LW/32; k++) l[k*32 +: 32] = $urandom | 32'h0101_0101;
    for (int k = 0; k < MW/32; k++) m[k*32 +: 32] = $urandom;
    drive(l, m, 1'b1, e);
    checks++;
    if (lifm_comp !== '0) begin errors++; $display("FAIL reset lifm_comp: slot %0d nonzero, required 0", ldiff(lifm_comp, '0)); end
    checks++;
    if (mt_comp !== '0) begin errors++; $display("FAIL reset mt_comp: slot %0d nonzero, required 0", mdiff(mt_comp, '0)); end
    checks++;
    if (comp_cnt !== 8'd0) begin errors++; $display("FAIL reset comp_cnt: got %0d, required 0", comp_cnt); end
  endtask

  task automatic test_sparse_back_to_back();
    logic [LW-1:0] ls[2];
    logic [MW-1:0] ms[2];
    logic [23:0]   lo[2];
    exp_t e;
    ls[0] = sp_l; ms[0] = sp_m; lo[0] = 24'h16_2F_0D;
    ls[1] = b2_l; ms[1] = b2_m; lo[1] = 24'h23_4A_0F;
    for (int n = 0; n < 2; n++) begin
      repeat (LAT) begin
        drive(ls[n], ms[n], 1'b0, e);
        checks++;
        if (lifm_comp !== e.l || mt_comp !== e.m || comp_cnt !== e.c) begin
          errors++;
          $display("FAIL sparse line %0d: comp_cnt %0d required %0d, lifm slot %0d, mt slot %0d differ",
                   n, comp_cnt, e.c, ldiff(lifm_comp, e.l), mdiff(mt_comp, e.m));
        end
      end
      checks++;
      if (lifm_comp[23:0] !== lo[n] || lifm_comp[LW-1:24] !== '0) begin
        errors++;
        $display("FAIL sparse words line %0d: slots0-2 %h required %h, first bad slot %0d",
                 n, lifm_comp[23:0], lo[n], ldiff(lifm_comp, {{(LW-24){1'b0}}, lo[n]}));
      end
      checks++;
      if (mt_comp[3*MT-1:0] !== {28'd1, 28'd1, 28'd1} || mt_comp[MW-1:3*MT] !== '0) begin
        errors++;
        $display("FAIL sparse mt line %0d: slot0 %0d slot3 %0d, required 1 and 0",
                 n, mt_comp[MT-1:0], mt_comp[3*MT +: MT]);
      end
      checks++;
      if (comp_cnt !== 8'd3) begin errors++; $display("FAIL sparse cnt line %0d: got %0d, required 3", n, comp_cnt); end
    end
  endtask

  task automatic test_extremes();
    logic [LW-1:0] ls[3], xl[3];
    logic [MW-1:0] ms[3], xm[3];
    logic [7:0]    xc[3];
    exp_t e;
    // all-zero words with junk metadata that must be dropped
    ls[0] = '0;
    for (int k = 0; k < MW/32; k++) ms[0][k*32 +: 32] = $urandom;
    xl[0] = '0; xm[0] = '0; xc[0] = 8'd0;
    // every word nonzero: identity
    for (int i = 0; i < NW; i++) begin
      ls[1][i*WW +: WW] = 8'(i + 1);
      ms[1][i*MT +: MT] = 28'(i);
    end
    xl[1] = ls[1]; xm[1] = ms[1]; xc[1] = 8'd128;
    // last index moves to slot 0; MT on zero word 3 is dropped
    ls[2] = '0; ms[2] = '0;
    ls[2][127*WW +: WW] = 8'hFF;
    ms[2][127*MT +: MT] = 28'd5;
    ms[2][3*MT +: MT]   = 28'd9;
    xl[2] = '0; xm[2] = '0; xc[2] = 8'd1;
    xl[2][WW-1:0] = 8'hFF;
    xm[2][MT-1:0] = 28'd5;
    for (int n = 0; n < 3; n++) begin
      repeat (LAT) begin
        drive(ls[n], ms[n], 1'b0, e);
        checks++;
        if (lifm_comp !== e.l || mt_comp !== e.m || comp_cnt !== e.c) begin
          errors++;
          $display("FAIL extreme case %0d: comp_cnt %0d required %0d, lifm slot %0d, mt slot %0d differ",
                   n, comp_cnt, e.c, ldiff(lifm_comp, e.l), mdiff(mt_comp, e.m));
        end
      end
      checks++;
      if (comp_cnt !== xc[n]) begin errors++; $display("FAIL extreme cnt case %0d: got %0d, required %0d", n, comp_cnt, xc[n]); end
      checks++;
      if (lifm_comp !== xl[n]) begin errors++; $display("FAIL extreme lifm case %0d: first bad slot %0d, slot0 %h required %h", n, ldiff(lifm_comp, xl[n]), lifm_comp[7:0], xl[n][7:0]); end
      checks++;
      if (mt_comp !== xm[n]) begin errors++; $display("FAIL extreme mt case %0d: first bad slot %0d, slot0 %0d required %0d", n, mdiff(mt_comp, xm[n]), mt_comp[MT-1:0], xm[n][MT-1:0]); end
    end
  endtask

  task automatic test_reset_midstream();
    exp_t e;
    drive(sp_l, sp_m, 1'b0, e);
    drive(sp_l, sp_m, 1'b1, e);
    checks++;
    if (lifm_comp !== '0 || mt_comp !== '0 || comp_cnt !== 8'd0) begin
      errors++;
      $display("FAIL midreset clear: comp_cnt %0d required 0, lifm slot %0d nonzero", comp_cnt, ldiff(lifm_comp, '0));
    end
    repeat (LAT) begin
      drive(b2_l, b2_m, 1'b0, e);
      checks++;
      if (lifm_comp !== e.l || mt_comp !== e.m || comp_cnt !== e.c) begin
        errors++;
        $display("FAIL midreset resume: comp_cnt %0d required %0d, lifm slot %0d, mt slot %0d differ",
                 comp_cnt, e.c, ldiff(lifm_comp, e.l), mdiff(mt_comp, e.m));
      end
    end
    checks++;
    if (comp_cnt !== 8'd3 || lifm_comp[23:0] !== 24'h23_4A_0F) begin
      errors++;
      $display("FAIL midreset line: comp_cnt %0d required 3, slots0-2 %h required 234a0f", comp_cnt, lifm_comp[23:0]);
    end
  endtask

  task automatic test_random();
    logic [LW-1:0] l;
    logic [MW-1:0] m;
    logic          r;
    int            d;
    exp_t          e;
    for (int n = 0; n < 40 + LAT - 1; n++) begin
      d = $urandom_range(100);
      for (int i = 0; i < NW; i++) begin
        l[i*WW +: WW] = ($urandom_range(99) < d) ? 8'($urandom_range(255, 1)) : 8'd0;
        m[i*MT +: MT] = 28'($urandom);
      end
      r = (n < 40) && ($urandom_range(15) == 0);
      drive(l, m, r, e);
      checks++;
      if (lifm_comp !== e.l || mt_comp !== e.m || comp_cnt !== e.c) begin
        errors++;
        $display("FAIL random line %0d: comp_cnt %0d required %0d, lifm slot %0d, mt slot %0d differ",
                 n, comp_cnt, e.c, ldiff(lifm_comp, e.l), mdiff(mt_comp, e.m));
      end
    end
  endtask

  initial begin
    sp_l = '0; sp_m = '0; b2_l = '0; b2_m = '0;
    sp_l[0*WW +: WW]  = 8'd13; sp_m[0*MT +: MT]  = 28'd1;
    sp_l[8*WW +: WW]  = 8'd47; sp_m[8*MT +: MT]  = 28'd1;
    sp_l[15*WW +: WW] = 8'd22; sp_m[15*MT +: MT] = 28'd1;
    b2_l[5*WW +: WW]  = 8'd15; b2_m[5*MT +: MT]  = 28'd1;
    b2_l[32*WW +: WW] = 8'd74; b2_m[32*MT +: MT] = 28'd1;
    b2_l[75*WW +: WW] = 8'd35; b2_m[75*MT +: MT] = 28'd1;
    reset = 1'b1;
    lifm_line = '0;
    mt_line = '0;

    test_reset();
    test_sparse_back_to_back();
    test_extremes();
    test_reset_midstream();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/zvc_compressor_128.md
Name: zvc_compressor_128

Overview:
- Zero-value compressor for one 128-word line of input feature-map (LIFM) data and its per-word metadata (MT, distance fields).
- Packs all nonzero LIFM words, with their MT entries, toward index 0 in original order. Zero-fills the remaining slots.
- Sits between the line buffer and the redundancy controller's compressed-line storage. Registered output.

Parameters:
- WORD_WIDTH, 8, bits per LIFM word
- DIST_WIDTH, 7, bits per distance field
- MAX_LIFM_RSIZ, 4, distance fields per word; MT entry width = DIST_WIDTH*MAX_LIFM_RSIZ
- LINE_SIZE, 128, words per line; fixed at 128, not overridable

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- lifm_line  input  LINE_SIZE*WORD_WIDTH  uncompressed line; word i at bits [i*WORD_WIDTH +: WORD_WIDTH]
- mt_line  input  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  metadata; entry i at [i*DIST_WIDTH*MAX_LIFM_RSIZ +: DIST_WIDTH*MAX_LIFM_RSIZ]
- lifm_comp  output  LINE_SIZE*WORD_WIDTH  compressed line, same packing
- mt_comp  output  LINE_SIZE*DIST_WIDTH*MAX_LIFM_RSIZ  compressed metadata, same packing
- comp_cnt  output  8  number of nonzero words in the compressed line (0..128)

Behaviour:
- Keep criterion: word i is kept iff lifm_line word i != 0. The MT entry is ignored when deciding; it always travels with its word.
- Destination of kept word i = number of kept words at indices 0..i-1 (exclusive prefix count, 8 bits). Relative order is preserved.
- Output slot j for j < comp_cnt holds the j-th kept word and its MT entry.
- Slots j >= comp_cnt hold 0 in both lifm_comp and mt_comp. No stale data is allowed.
- The datapath is purely combinational: prefix count followed by a per-slot one-hot select/OR.
- All outputs are registered. Latency is 1 cycle: inputs sampled at edge N appear on outputs after edge N.
- A new line is accepted every cycle. There is no handshake; outputs track inputs continuously.
- Reset (synchronous, active-high): at a clock edge with reset=1, lifm_comp, mt_comp and comp_cnt all become 0. Reset takes priority over data. Reset asserted mid-stream discards the line sampled at that edge. The first line after reset deassertion appears one cycle later.
- Boundaries:
  - All-zero line: all outputs 0.
  - All-nonzero line: output equals input, comp_cnt=128 (needs the full 8 bits).
  - Single nonzero word at index 127: it moves to slot 0.
  - Nonzero MT on a zero LIFM word is dropped.

Optional Feature:
- Macro ZVC_PIPE2_EN.
- When defined: a second register stage is inserted after the prefix-count computation. Latency becomes 2 cycles and throughput stays 1 line per cycle. Reset clears both stages, so outputs read 0 for 2 cycles after reset deassertion.
- When undefined: single stage, 1-cycle latency as above.

Decomposition:
- Shared package zvc_pkg holds:
  - constants LINE_SIZE=128 and CNT_WIDTH=8
  - default WORD_WIDTH/DIST_WIDTH/MAX_LIFM_RSIZ
  - derived MT_WIDTH
- One sub-module, zvc_prefix_count: input 128-bit nonzero mask; outputs 128 exclusive prefix counts (8 bits each) and the total count. The parent does the slot select and the registers.

Test Plan:
- Reset: hold reset=1 for 1 edge with arbitrary input -> lifm_comp=0, mt_comp=0, comp_cnt=0.
- Sparse line: LIFM 13@0, 47@8, 22@15, MT=1 at those indices, rest 0 -> next cycle lifm_comp[0..2]=13,47,22; mt_comp[0..2]=1; slots 3..127 = 0; comp_cnt=3.
- Back-to-back unordered indices: next cycle LIFM 15@5, 74@32, 35@75, MT=1 at each -> lifm_comp[0..2]=15,74,35; mt_comp[0..2]=1; previous line's data fully cleared; comp_cnt=3.
- Extremes: all-zero line -> all 0, comp_cnt=0. Line with word i = i+1 for all i (all nonzero), MT entry i = i -> outputs identical to inputs, comp_cnt=128.
- Last index and MT drop: LIFM 0xFF@127 only, MT=5@127 and MT=9@3 -> lifm_comp[0]=0xFF, mt_comp[0]=5, all other slots 0, comp_cnt=1.
- Reset mid-stream: drive the sparse line, assert reset at the next edge -> outputs 0. Deassert -> the following line appears after 1 cycle (2 cycles with ZVC_PIPE2_EN).
